downsample_frame_loader: RTL and testbench

- Upstream stage of the downsample datapath.
- Converts a raster-order pixel stream (valid/ready) into a complete HIN x HIN feature map, presented as a flattened parallel bus to the downsample core's ifmap input.
- Ping-pong buffered: one frame is loaded while the previous frame is held stable for downstream consumption.

---
 rtl/downsample_frame_loader.sv | 63 ++++++
 tb/tb_downsample_frame_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/downsample_frame_loader.sv
// downsample_frame_loader: ping-pong buffers a raster pixel stream into full HIN x HIN frames for the downsample core
module downsample_frame_loader #(
  parameter int HIN = 27,
  parameter int DW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HIN*HIN*DW-1:0] frame_data,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);
  localparam int RW = $clog2(HIN);
  logic [HIN*HIN*DW-1:0] mem [2];
  logic [1:0]    full;
  logic          wr_sel, rd_sel;
  logic [RW-1:0] row, col;
  logic          acc, rel, col_end, at_last;
  int            idx;
  assign in_ready   = ~full[wr_sel];
  assign out_valid  = full[rd_sel];
  assign frame_data = mem[rd_sel];
  assign acc        = in_valid & in_ready;
  assign rel        = out_valid & out_ready;
  assign col_end    = col == RW'(HIN - 1);
  assign at_last    = col_end & (row == RW'(HIN - 1));
  assign idx        = int'(row) * HIN + int'(col);
  // Pixel storage carries no reset; its contents only matter once a bank is full.
  always_ff @(posedge clk)
    if (acc) mem[wr_sel][idx*DW +: DW] <= in_data;
  // Accept and release always target different banks, so both may act on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      row       <= '0;
      col       <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (acc) begin
        if (in_last != at_last) frame_err <= 1'b1;
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= at_last ? '0 : row + 1'b1;
        if (at_last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (rel) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        frame_cnt    <= frame_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_downsample_frame_loader.sv
// tb_downsample_frame_loader: table vectors plus randomized traffic checked against a frame-queue reference model
module tb_downsample_frame_loader;
  localparam int HIN = 27;
  localparam int DW  = 8;
  localparam int N   = HIN * HIN;
  localparam int FW  = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, frame_err;
  logic [FW-1:0] frame_data;
  logic [15:0]   frame_cnt;

  downsample_frame_loader #(.HIN(HIN), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .frame_data(frame_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: completed frames wait in a queue, head is the one presented.
  logic [FW-1:0] pend [$];
  logic [FW-1:0] cur;
  int            pos, m_cnt, checks, passed;
  bit            m_err;

  typedef struct {int r; int c; logic [DW-1:0] exp;} vec_t;
  vec_t tbl [8];

  function automatic logic [DW-1:0] pix(input int p, input int off);
    return DW'((10 * (p / HIN + p % HIN) + off) % 256);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_frame(input string nm);
    logic [FW-1:0] e;
    int k;
    e = pend[0];
    checks++;
    if (frame_data === e) passed++;
    else begin
      k = 0;
      while (k < N - 1 && frame_data[k*DW +: DW] === e[k*DW +: DW]) k++;
      $display("FAIL %s: pixel %0d got %0d expected %0d", nm, k, frame_data[k*DW +: DW], e[k*DW +: DW]);
    end
  endtask

  task automatic chk_pix(input string nm, input int r, input int c, input logic [DW-1:0] exp);
    chk($sformatf("%s(%0d,%0d)", nm, r, c), longint'(frame_data[(r*HIN+c)*DW +: DW]), longint'(exp));
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    bit a, rl;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    a  = v && pend.size() < 2;
    rl = r && pend.size() > 0;
    @(posedge clk); #1;
    if (a) begin
      cur[pos*DW +: DW] = d;
      if (l != (pos == N - 1)) m_err = 1'b1;
      pos++;
      if (pos == N) begin
        pend.push_back(cur);
        pos = 0;
      end
    end
    if (rl) begin
      pend.delete(0);
      m_cnt = (m_cnt + 1) % 65536;
    end
    chk("in_ready", longint'(in_ready), longint'(pend.size() < 2));
    chk("out_valid", longint'(out_valid), longint'(pend.size() > 0));
    chk("frame_err", longint'(frame_err), longint'(m_err));
    chk("frame_cnt", longint'(frame_cnt), longint'(m_cnt));
    if (pend.size() > 0) chk_frame("frame_data");
  endtask

  task automatic send(input int off, input int gap, input int rdy, input int early, input bit drop, input int npix);
    int p, g;
    logic v, l;
    bit a;
    p = 0;
    g = 0;
    while (p < npix && g < 20000) begin
      v = $urandom_range(99) >= gap;
      l = (p == early) || (p == N - 1 && !drop);
      a = v && pend.size() < 2;
      cyc(v, pix(p, off), l, $urandom_range(99) < rdy);
      if (a) p++;
      g++;
    end
    chk("send_budget", longint'(p), longint'(npix));
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pend.delete();
    pos = 0; m_err = 1'b0; m_cnt = 0;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_frame_err", longint'(frame_err), 0);
    chk("rst_frame_cnt", longint'(frame_cnt), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    checks = 0; passed = 0;
    tbl[0] = '{0, 0, 8'd0};    tbl[1] = '{1, 2, 8'd30};   tbl[2] = '{26, 26, 8'd8};
    tbl[3] = '{0, 26, 8'd4};   tbl[4] = '{26, 0, 8'd4};   tbl[5] = '{13, 13, 8'd4};
    tbl[6] = '{5, 7, 8'd120};  tbl[7] = '{3, 22, 8'd250};
    do_reset();
    // Single frame, no consumer
    send(0, 0, 0, -1, 1'b0, N);
    chk("f1_out_valid", longint'(out_valid), 1);
    chk("f1_frame_err", longint'(frame_err), 0);
    for (int i = 0; i < 8; i++) chk_pix("f1_pix", tbl[i].r, tbl[i].c, tbl[i].exp);
    // Second frame fills the other bank, third stalls
    send(1, 0, 0, -1, 1'b0, N);
    chk("both_full_in_ready", longint'(in_ready), 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, pix(0, 2), 1'b0, 1'b0);
    chk_pix("stall_pix", 1, 2, 8'd30);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("rel_frame_cnt", longint'(frame_cnt), 1);
    chk_pix("rel_pix", 1, 2, 8'd31);
    chk("rel_in_ready", longint'(in_ready), 1);
    send(2, 0, 0, -1, 1'b0, N);
    // Random gaps and consumer over four frames
    do_reset();
    for (int f = 0; f < 4; f++) send(f * 37 + 5, 30, 30, -1, 1'b0, N);
    g = 0;
    while (pend.size() > 0 && g < 5000) begin
      cyc(1'b0, '0, 1'b0, $urandom_range(99) < 50);
      g++;
    end
    chk("drain_left", longint'(pend.size()), 0);
    chk("rand_frame_cnt", longint'(frame_cnt), 4);
    // Early in_last on pixel 100
    do_reset();
    send(3, 0, 0, 99, 1'b0, N);
    chk("early_err", longint'(frame_err), 1);
    chk("early_out_valid", longint'(out_valid), 1);
    // Missing in_last, then a normal frame
    do_reset();
    send(4, 0, 0, -1, 1'b1, N);
    chk("miss_err", longint'(frame_err), 1);
    chk("miss_out_valid", longint'(out_valid), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    send(5, 0, 0, -1, 1'b0, N);
    chk("miss_next_valid", longint'(out_valid), 1);
    chk_pix("miss_next_pix", 26, 26, pix(N - 1, 5));
    // Reset with one frame pending and a partial frame
    do_reset();
    send(6, 0, 0, -1, 1'b0, N);
    send(7, 0, 0, -1, 1'b0, 400);
    do_reset();
    send(8, 0, 0, -1, 1'b0, N);
    chk("post_rst_valid", longint'(out_valid), 1);
    chk_pix("post_rst_pix", 0, 0, pix(0, 8));
    chk_pix("post_rst_pix", 26, 26, pix(N - 1, 8));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
